// File: rtl/zone_pump_arbiter.sv
// ---------------------------------------------------------------------------
// zone_pump_arbiter
//
// Purpose:
//   Shares one irrigation pump between NUM_ZONES watering requesters. Zones
//   are served one at a time in round-robin order. For each grant the zone's
//   valve opens, settles for VALVE_SETTLE cycles with the pump off, the pump
//   runs for the requested duration, and then pump and valves stay off for
//   REST_CYCLES before the next arbitration. A requester that drops its
//   request while its valve is open aborts the grant (no done pulse).
//   A zero-length request completes immediately with a done pulse and no grant.
//
// Ports:
//   clk       in   system clock, all logic on posedge
//   rst_n     in   synchronous reset, active low
//   req       in   per-zone watering request, held until done/abort
//   req_time  in   per-zone duration, zone z = bits [z*TIME_W +: TIME_W]
//   grant     out  one-hot valve-open (zero when no grant)
//   pump_on   out  pump motor enable
//   done      out  one-cycle pulse per completed watering
//   busy      out  high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module zone_pump_arbiter #(
    parameter int NUM_ZONES    = 4,
    parameter int TIME_W       = 8,
    parameter int VALVE_SETTLE = 4,
    parameter int REST_CYCLES  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_ZONES-1:0]        req,
    input  logic [NUM_ZONES*TIME_W-1:0] req_time,
    output logic [NUM_ZONES-1:0]        grant,
    output logic                        pump_on,
    output logic [NUM_ZONES-1:0]        done,
    output logic                        busy
);

    localparam int IDX_W = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_PUMP,
        S_REST
    } state_t;

    state_t               state_q, state_d;
    logic [TIME_W-1:0]    cnt_q, cnt_d;
    logic [TIME_W-1:0]    dur_q, dur_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [NUM_ZONES-1:0] grant_q, grant_d;
    logic [NUM_ZONES-1:0] done_q, done_d;
    logic                 pump_q, pump_d;
    logic                 busy_q;

    logic                 found;
    logic [IDX_W-1:0]     sel;
    logic [IDX_W-1:0]     sel_next;
    logic [TIME_W-1:0]    sel_time;
    logic [NUM_ZONES-1:0] sel_onehot;

    // Round-robin pick: scan offsets from the highest down so the last hit
    // written is the requester closest to rr_q (rr_q itself has top priority).
    always_comb begin
        int               k;
        logic [IDX_W-1:0] k_idx;
        found = 1'b0;
        sel   = '0;
        k     = 0;
        k_idx = '0;
        for (int i = NUM_ZONES - 1; i >= 0; i--) begin
            k = int'(rr_q) + i;
            if (k >= NUM_ZONES) begin
                k = k - NUM_ZONES;
            end
            k_idx = IDX_W'(k);
            if (req[k_idx]) begin
                found = 1'b1;
                sel   = k_idx;
            end
        end
    end

    always_comb begin
        sel_time        = req_time[int'(sel)*TIME_W +: TIME_W];
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
        sel_next        = (int'(sel) == NUM_ZONES - 1) ? '0 : sel + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dur_d   = dur_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        pump_d  = pump_q;
        done_d  = '0;

        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                pump_d  = 1'b0;
                if (found) begin
                    rr_d = sel_next;
                    if (sel_time == '0) begin
                        done_d = sel_onehot;
                    end else begin
                        state_d = S_OPEN;
                        grant_d = sel_onehot;
                        dur_d   = sel_time;
                        cnt_d   = TIME_W'(VALVE_SETTLE - 1);
                    end
                end
            end

            S_OPEN, S_PUMP: begin
                // grant_q is one-hot on the served zone, so masking req with
                // it tells us whether that zone still wants water.
                if ((req & grant_q) == '0) begin
                    state_d = S_REST;
                    grant_d = '0;
                    pump_d  = 1'b0;
                    cnt_d   = TIME_W'(REST_CYCLES - 1);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (state_q == S_OPEN) begin
                    state_d = S_PUMP;
                    pump_d  = 1'b1;
                    cnt_d   = dur_q - 1'b1;
                end else begin
                    state_d = S_REST;
                    grant_d = '0;
                    pump_d  = 1'b0;
                    done_d  = grant_q;
                    cnt_d   = TIME_W'(REST_CYCLES - 1);
                end
            end

            S_REST: begin
                grant_d = '0;
                pump_d  = 1'b0;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                pump_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            pump_q  <= 1'b0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            pump_q  <= pump_d;
            done_q  <= done_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // Latched duration is only read after it has been loaded, so it needs no reset.
    always_ff @(posedge clk) begin
        dur_q <= dur_d;
    end

    assign grant   = grant_q;
    assign pump_on = pump_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_zone_pump_arbiter.sv
// ---------------------------------------------------------------------------
// tb_zone_pump_arbiter
//
// Purpose:
//   Self-checking bench for zone_pump_arbiter. A timeline model predicts, for
//   every clock edge, the window of cycles in which each grant, pump run and
//   done pulse occur, computed directly from the arbitration and timing rules.
//   Directed scenarios check fixed cycle numbers; a randomized run compares
//   every cycle against the model and checks the output invariants.
// ---------------------------------------------------------------------------
module tb_zone_pump_arbiter;

    localparam int N  = 4;
    localparam int TW = 8;
    localparam int VS = 4;
    localparam int RS = 16;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic [N-1:0]    req      = '0;
    logic [N*TW-1:0] req_time = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            pump_on;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Edge counter and model timeline (all in edge numbers).
    int ecnt   = 0;
    int m_rr   = 0;
    int m_z    = 0;
    int m_gs   = 1;
    int m_ge   = 0;
    int m_ps   = 1;
    int m_pe   = 0;
    int m_done = -1;
    int m_dz   = 0;
    int m_idle = 0;

    zone_pump_arbiter #(
        .NUM_ZONES    (N),
        .TIME_W       (TW),
        .VALVE_SETTLE (VS),
        .REST_CYCLES  (RS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_time (req_time),
        .grant    (grant),
        .pump_on  (pump_on),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] oh(int z);
        logic [N-1:0] v;
        v    = '0;
        v[z] = 1'b1;
        return v;
    endfunction

    // Called once per edge with the inputs the DUT sampled on that edge.
    function automatic void model_edge();
        int x;
        int z;
        int dur;
        x = ecnt;
        if (!rst_n) begin
            m_rr   = 0;
            m_gs   = x + 1;
            m_ge   = x;
            m_ps   = x + 1;
            m_pe   = x;
            m_done = -1;
            m_idle = x;
        end else if (x - 1 >= m_idle) begin
            if (req != '0) begin
                z = m_rr;
                while (!req[z]) z = (z + 1) % N;
                dur  = int'(req_time[z*TW +: TW]);
                m_rr = (z + 1) % N;
                m_dz = z;
                if (dur == 0) begin
                    m_done = x;
                    m_idle = x;
                end else begin
                    m_z    = z;
                    m_gs   = x;
                    m_ge   = x + VS + dur - 1;
                    m_ps   = x + VS;
                    m_pe   = m_ge;
                    m_done = x + VS + dur;
                    m_idle = m_done + RS;
                end
            end
        end else if (x - 1 >= m_gs && x - 1 <= m_ge && !req[m_z]) begin
            m_ge   = x - 1;
            if (m_pe > x - 1) m_pe = x - 1;
            m_done = -1;
            m_idle = x + RS;
        end
    endfunction

    function automatic logic [N-1:0] e_grant();
        return (ecnt >= m_gs && ecnt <= m_ge) ? oh(m_z) : '0;
    endfunction

    function automatic logic e_pump();
        return (ecnt >= m_ps && ecnt <= m_pe);
    endfunction

    function automatic logic [N-1:0] e_done();
        return (ecnt == m_done) ? oh(m_dz) : '0;
    endfunction

    function automatic logic e_busy();
        return (ecnt < m_idle);
    endfunction

    task automatic step();
        @(posedge clk);
        ecnt++;
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_time(int z, int t);
        req_time[z*TW +: TW] = TW'(t);
    endtask

    task automatic test_reset();
        req = 4'b1011;
        set_time(0, 7);
        set_time(1, 7);
        set_time(3, 7);
        rst_n = 1'b0;
        step();
        step();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_tests++; if (pump_on !== 1'b0)  begin n_fail++; $display("FAIL reset_pump: got %b want 0", pump_on); end
        n_tests++; if (done !== 4'b0000)  begin n_fail++; $display("FAIL reset_done: got %b want 0000", done); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        req   = '0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [N-1:0] wg;
        logic [N-1:0] wd;
        logic         wp;
        logic         wb;
        do_reset();
        req = 4'b0100;
        set_time(2, 5);
        for (int k = 1; k <= 30; k++) begin
            step();
            wg = (k >= 1 && k <= 9) ? 4'b0100 : 4'b0000;
            wp = (k >= 5 && k <= 9);
            wd = (k == 10) ? 4'b0100 : 4'b0000;
            wb = (k <= 25);
            n_tests++; if (grant !== wg)  begin n_fail++; $display("FAIL single_grant c%0d: got %b want %b", k, grant, wg); end
            n_tests++; if (pump_on !== wp) begin n_fail++; $display("FAIL single_pump c%0d: got %b want %b", k, pump_on, wp); end
            n_tests++; if (done !== wd)   begin n_fail++; $display("FAIL single_done c%0d: got %b want %b", k, done, wd); end
            n_tests++; if (busy !== wb)   begin n_fail++; $display("FAIL single_busy c%0d: got %b want %b", k, busy, wb); end
            if (k == 10) req = '0;
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] prev;
        int           ngr;
        int           zrun;
        int           zi;
        do_reset();
        req = 4'b1111;
        for (int z = 0; z < N; z++) set_time(z, 3);
        prev = '0;
        ngr  = 0;
        zrun = 0;
        for (int c = 0; c < 200 && ngr < 5; c++) begin
            step();
            if (grant != '0 && prev == '0) begin
                zi = -1;
                for (int z = 0; z < N; z++) if (grant == oh(z)) zi = z;
                n_tests++; if (zi !== (ngr % N)) begin n_fail++; $display("FAIL rr_order #%0d: got grant %b want zone %0d", ngr, grant, ngr % N); end
                if (ngr > 0) begin
                    n_tests++; if (zrun !== RS + 1) begin n_fail++; $display("FAIL rr_gap #%0d: got %0d want %0d", ngr, zrun, RS + 1); end
                end
                ngr++;
            end
            if (grant == '0) zrun++; else zrun = 0;
            prev = grant;
        end
        n_tests++; if (ngr !== 5) begin n_fail++; $display("FAIL rr_count: got %0d grants want 5", ngr); end
        req = '0;
    endtask

    task automatic test_abort();
        int first_idle;
        int grant_k;
        logic [N-1:0] g_seen;
        do_reset();
        req = 4'b0010;
        set_time(1, 20);
        for (int k = 1; k <= 7; k++) step();
        n_tests++; if (pump_on !== 1'b1 || grant !== 4'b0010) begin n_fail++; $display("FAIL abort_pre: got grant %b pump %b want 0010 1", grant, pump_on); end
        req = 4'b0000;
        step();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL abort_grant: got %b want 0000", grant); end
        n_tests++; if (pump_on !== 1'b0)  begin n_fail++; $display("FAIL abort_pump: got %b want 0", pump_on); end
        n_tests++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL abort_busy: got %b want 1", busy); end
        n_tests++; if (done !== 4'b0000)  begin n_fail++; $display("FAIL abort_done: got %b want 0000", done); end
        req = 4'b0110;
        set_time(2, 4);
        first_idle = -1;
        grant_k    = -1;
        g_seen     = '0;
        for (int k = 9; k <= 40 && grant_k < 0; k++) begin
            step();
            n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL abort_nodone c%0d: got %b want 0000", k, done); end
            if (busy == 1'b0 && first_idle < 0) first_idle = k;
            if (grant != '0) begin
                grant_k = k;
                g_seen  = grant;
            end
        end
        n_tests++; if (first_idle !== 24) begin n_fail++; $display("FAIL abort_rest_len: idle at c%0d want c24", first_idle); end
        n_tests++; if (grant_k !== 25)    begin n_fail++; $display("FAIL abort_regrant_time: got c%0d want c25", grant_k); end
        n_tests++; if (g_seen !== 4'b0100) begin n_fail++; $display("FAIL abort_rr_next: got %b want 0100", g_seen); end
        req = '0;
    endtask

    task automatic test_zero_dur();
        do_reset();
        req = 4'b1000;
        set_time(3, 0);
        step();
        n_tests++; if (done !== 4'b1000)  begin n_fail++; $display("FAIL zero_done: got %b want 1000", done); end
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL zero_grant: got %b want 0000", grant); end
        n_tests++; if (pump_on !== 1'b0)  begin n_fail++; $display("FAIL zero_pump: got %b want 0", pump_on); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL zero_busy: got %b want 0", busy); end
        req = '0;
        step();
        n_tests++; if (done !== 4'b0000)  begin n_fail++; $display("FAIL zero_done_end: got %b want 0000", done); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL zero_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_pump();
        do_reset();
        req = 4'b0011;
        set_time(0, 10);
        set_time(1, 3);
        for (int k = 1; k <= 6; k++) step();
        n_tests++; if (grant !== 4'b0001 || pump_on !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got grant %b pump %b want 0001 1", grant, pump_on); end
        rst_n = 1'b0;
        step();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_grant: got %b want 0000", grant); end
        n_tests++; if (pump_on !== 1'b0)  begin n_fail++; $display("FAIL rstmid_pump: got %b want 0", pump_on); end
        n_tests++; if (done !== 4'b0000)  begin n_fail++; $display("FAIL rstmid_done: got %b want 0000", done); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        step();
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_regrant: got %b want 0001", grant); end
        n_tests++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL rstmid_rebusy: got %b want 1", busy); end
        req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] wg;
        logic [N-1:0] wd;
        logic         wp;
        logic         wb;
        int           t;
        do_reset();
        req = '0;
        for (int c = 0; c < 10000 && n_fail < 50; c++) begin
            for (int z = 0; z < N; z++) begin
                if ($urandom_range(0, 29) == 0) req[z] = ~req[z];
            end
            if ($urandom_range(0, 7) == 0) begin
                t = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
                set_time(int'($urandom_range(0, N - 1)), t);
            end
            rst_n = ($urandom_range(0, 2999) != 0);
            step();
            wg = e_grant();
            wp = e_pump();
            wd = e_done();
            wb = e_busy();
            n_tests++; if (grant !== wg)   begin n_fail++; $display("FAIL rand_grant e%0d: got %b want %b", ecnt, grant, wg); end
            n_tests++; if (pump_on !== wp) begin n_fail++; $display("FAIL rand_pump e%0d: got %b want %b", ecnt, pump_on, wp); end
            n_tests++; if (done !== wd)    begin n_fail++; $display("FAIL rand_done e%0d: got %b want %b", ecnt, done, wd); end
            n_tests++; if (busy !== wb)    begin n_fail++; $display("FAIL rand_busy e%0d: got %b want %b", ecnt, busy, wb); end
            n_tests++; if (!$onehot0(grant)) begin n_fail++; $display("FAIL rand_onehot e%0d: got %b want one-hot or zero", ecnt, grant); end
            n_tests++; if (pump_on && !$onehot(grant)) begin n_fail++; $display("FAIL rand_pump_grant e%0d: got grant %b want one bit with pump", ecnt, grant); end
            n_tests++; if (!$onehot0(done)) begin n_fail++; $display("FAIL rand_done_onehot e%0d: got %b want at most one bit", ecnt, done); end
            n_tests++; if ((done & grant) != '0) begin n_fail++; $display("FAIL rand_done_grant e%0d: got done %b grant %b want disjoint", ecnt, done, grant); end
        end
        rst_n = 1'b1;
        req   = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_zero_dur();
        test_reset_mid_pump();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
